// File: rtl/eth_pkg.sv
// Shared constants and types for the Ethernet TX scheduler.
package eth_pkg;

  localparam int unsigned N_SRC   = 3;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STALL_W = 16;
  localparam int unsigned IFG_W   = 8;

  // Source indices into the per-source vectors and the grant bits
  localparam int unsigned SRC_ARP  = 0;
  localparam int unsigned SRC_PING = 1;
  localparam int unsigned SRC_UDP  = 2;

  // Scheduler state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_XFER  = 3'd1;
  localparam logic [2:0] ST_ABORT = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_IFG   = 3'd4;

  // One beat of the TX stream
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    logic              vld;
  } tx_beat_t;

  // Fixed priority pick: lowest index wins (ARP > ping > UDP)
  function automatic logic [N_SRC-1:0] arb_pick(input logic [N_SRC-1:0] req);
    logic [N_SRC-1:0] pick;
    pick = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (req[i] && (pick == '0)) pick[i] = 1'b1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/eth_tx_sched.sv
// Arbitrates ARP / ping / UDP frame sources onto a single TX stream with
// inter-frame gap, stall timeout and per-source completion pulses.
module eth_tx_sched
  import eth_pkg::*;
#(
  parameter int unsigned IFG_CYCLES     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_arp_req_flag,
  output logic                    o_clear_arp_req,
  input  logic                    i_ping_req_flag,
  output logic                    o_clear_ping_req,
  input  logic                    i_udp_req,
  output logic                    o_udp_ack,
  output logic [N_SRC-1:0]        o_grant,
  input  logic [N_SRC*DATA_W-1:0] i_src_data,
  input  logic [N_SRC-1:0]        i_src_sop,
  input  logic [N_SRC-1:0]        i_src_eop,
  input  logic [N_SRC-1:0]        i_src_vld,
  output logic [N_SRC-1:0]        o_src_rdy,
  output logic [DATA_W-1:0]       o_tx_data,
  output logic                    o_tx_sop,
  output logic                    o_tx_eop,
  output logic                    o_tx_vld,
  input  logic                    i_tx_rdy,
  output logic                    o_busy,
  output logic                    o_timeout
);

  logic [2:0]         state_q, state_d;
  logic [N_SRC-1:0]   grant_q, grant_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [IFG_W-1:0]   ifg_q, ifg_d;
  logic [N_SRC-1:0]   done_q, done_d;
  logic               timeout_q, timeout_d;
  logic               busy_q, busy_d;
  logic [N_SRC-1:0]   req_c;
  tx_beat_t           sel_c;
  tx_beat_t           tx_c;

  assign req_c[SRC_ARP]  = i_arp_req_flag;
  assign req_c[SRC_PING] = i_ping_req_flag;
  assign req_c[SRC_UDP]  = i_udp_req;

  // Select the granted source's beat (grant is one-hot or zero)
  always_comb begin
    sel_c = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (grant_q[i]) begin
        sel_c.data = sel_c.data | i_src_data[i*DATA_W +: DATA_W];
        sel_c.sop  = sel_c.sop  | i_src_sop[i];
        sel_c.eop  = sel_c.eop  | i_src_eop[i];
        sel_c.vld  = sel_c.vld  | i_src_vld[i];
      end
    end
  end

  // Next-state, counters, pulses and the combinational TX datapath
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    stall_d   = stall_q;
    ifg_d     = ifg_q;
    done_d    = '0;
    timeout_d = 1'b0;
    tx_c      = '0;
    o_src_rdy = '0;
    case (state_q)
      ST_IDLE: begin
        stall_d = '0;
        ifg_d   = '0;
        grant_d = arb_pick(req_c);
        if (|req_c) state_d = ST_XFER;
      end
      ST_XFER: begin
        tx_c      = sel_c;
        o_src_rdy = grant_q & {N_SRC{i_tx_rdy}};
        if (sel_c.vld && i_tx_rdy) begin
          stall_d = '0;
          if (sel_c.eop) begin
            state_d = ST_DONE;
            done_d  = grant_q;
          end
        end else if (stall_q == STALL_W'(TIMEOUT_CYCLES - 2)) begin
          state_d = ST_ABORT;
        end else begin
          stall_d = stall_q + STALL_W'(1);
        end
      end
      ST_ABORT: begin
        // Terminate the frame at the MAC with an empty eop beat
        tx_c.vld = 1'b1;
        tx_c.eop = 1'b1;
        if (i_tx_rdy) begin
          timeout_d = 1'b1;
          done_d    = grant_q;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        grant_d = '0;
        ifg_d   = '0;
        state_d = ST_IFG;
      end
      ST_IFG: begin
        if (ifg_q == IFG_W'(IFG_CYCLES - 1)) state_d = ST_IDLE;
        else                                 ifg_d   = ifg_q + IFG_W'(1);
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      stall_q   <= '0;
      ifg_q     <= '0;
      done_q    <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      stall_q   <= stall_d;
      ifg_q     <= ifg_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end

  assign o_grant          = grant_q;
  assign o_clear_arp_req  = done_q[SRC_ARP];
  assign o_clear_ping_req = done_q[SRC_PING];
  assign o_udp_ack        = done_q[SRC_UDP];
  assign o_timeout        = timeout_q;
  assign o_busy           = busy_q;
  assign o_tx_data        = tx_c.data;
  assign o_tx_sop         = tx_c.sop;
  assign o_tx_eop         = tx_c.eop;
  assign o_tx_vld         = tx_c.vld;

endmodule
